// File: rtl/pipeline_to_pulse_pkg.sv
// Shared types and constants for the ready/valid to start-pulse converter.
package pipeline_to_pulse_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } issue_state_e;

    localparam int BUFFER_DEPTH = 2;
    localparam int OCC_W        = $clog2(BUFFER_DEPTH + 1);

    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUFFER_DEPTH);

endpackage

// File: rtl/pipeline_to_pulse_buffer.sv
// Two-entry FIFO-ordered word buffer; input_ready is registered from the next occupancy.
module pipeline_to_pulse_buffer
    import pipeline_to_pulse_pkg::*;
#(
    parameter int WORD_WIDTH = 0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WORD_WIDTH-1:0] push_data,
    output logic [WORD_WIDTH-1:0] head_data,
    output logic                  not_empty,
    output logic                  input_ready
);

    logic [WORD_WIDTH-1:0] entry_q [BUFFER_DEPTH];
    logic [WORD_WIDTH-1:0] entry_d [BUFFER_DEPTH];
    logic [OCC_W-1:0]      count_q, count_d;
    logic                  ready_q, ready_d;

    // Entry 0 is always the head; a pop shifts entry 1 forward before any push lands.
    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (pop && (count_q != '0)) begin
            entry_d[0] = entry_q[1];
            count_d    = count_q - OCC_W'(1);
        end
        if (push && (count_d < DEPTH_OCC)) begin
            if (count_d == '0) begin
                entry_d[0] = push_data;
            end else begin
                entry_d[1] = push_data;
            end
            count_d = count_d + OCC_W'(1);
        end
        ready_d = (count_d < DEPTH_OCC);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        entry_q <= entry_d;
    end

    assign head_data   = entry_q[0];
    assign not_empty   = (count_q != '0);
    assign input_ready = ready_q;

endmodule

// File: rtl/pipeline_to_pulse.sv
// Ready/valid to one-cycle start pulse converter for iterative modules.
// Optional PIPELINE_TO_PULSE_CHECK_EN adds a sticky protocol_error output.
module pipeline_to_pulse
    import pipeline_to_pulse_pkg::*;
#(
    parameter int WORD_WIDTH = 0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [WORD_WIDTH-1:0] input_data,
    output logic [WORD_WIDTH-1:0] module_data_in,
    output logic                  module_data_in_valid,
    input  logic                  module_ready
`ifdef PIPELINE_TO_PULSE_CHECK_EN
    ,
    output logic                  protocol_error
`endif
);

    logic                  push;
    logic                  issue;
    logic                  buf_not_empty;
    logic [WORD_WIDTH-1:0] buf_head;

    issue_state_e          state_q, state_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  pulse_q, pulse_d;

    assign push = input_valid & input_ready;

    pipeline_to_pulse_buffer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_buffer (
        .clock       (clock),
        .clear_n     (clear_n),
        .push        (push),
        .pop         (issue),
        .push_data   (input_data),
        .head_data   (buf_head),
        .not_empty   (buf_not_empty),
        .input_ready (input_ready)
    );

    // A module_ready coinciding with the pulse is still taken as completion of that word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pulse_d = 1'b0;
        issue   = 1'b0;
        if (state_q == IDLE) begin
            issue = buf_not_empty;
        end else if (module_ready) begin
            if (buf_not_empty) begin
                issue = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
        if (issue) begin
            data_d  = buf_head;
            pulse_d = 1'b1;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            pulse_q <= pulse_d;
        end
    end

    assign module_data_in       = data_q;
    assign module_data_in_valid = pulse_q;

`ifdef PIPELINE_TO_PULSE_CHECK_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q | (module_ready & ((state_q == IDLE) | pulse_q));
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign protocol_error = error_q;
`endif

endmodule
